// File: rtl/transfer_unit_if.sv
// rtl/transfer_unit_if.sv - data-memory port between transfer_unit (master) and memory (slave)
interface transfer_unit_if;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       mem_we;
  logic       mem_req;
  logic       mem_ack;

  modport master (
    output mem_addr, mem_wdata, mem_we, mem_req,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_we, mem_req,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/transfer_unit.sv
// rtl/transfer_unit.sv - Edulent register-transfer executor for the control unit's transfer micro-commands
// `EDULENT_MEM_HANDSHAKE_EN selects the req/ack memory FSM; otherwise memory is single-cycle, async read.
module transfer_unit #(
  parameter logic [7:0] PC_RESET = 8'h00,
  parameter logic [7:0] SP_RESET = 8'hFF
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic [3:0]      i_transfer_cmd,
  input  logic            i_sel_ap,
  input  logic            i_inc_pc,
  input  logic [1:0]      i_inc_dec_sp,
  input  logic [7:0]      i_alu_result,
  input  logic [7:0]      i_in_data,
  transfer_unit_if.master mem,
  output logic [7:0]      o_opcode,
  output logic [7:0]      o_a,
  output logic [7:0]      o_ap,
  output logic [7:0]      o_pc,
  output logic [7:0]      o_sp,
  output logic [7:0]      o_out_data,
  output logic            o_out_valid,
  output logic            o_busy
);
  logic [7:0] pc, sp, ma, md, ir, a, ap, out_data;
  logic       out_valid;
  logic       accept;
  logic       rd_done;
  logic [3:0] cmd;
  logic [1:0] sp_step;

`ifdef EDULENT_MEM_HANDSHAKE_EN
  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} mem_state_t;
  mem_state_t state, state_nxt;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rd_done   = 1'b0;
    case (state)
      IDLE: begin
        if (i_transfer_cmd == 4'h2)      state_nxt = RD_WAIT;
        else if (i_transfer_cmd == 4'h9) state_nxt = WR_WAIT;
      end
      RD_WAIT: begin
        if (mem.mem_ack) begin
          state_nxt = IDLE;
          rd_done   = 1'b1;
        end
      end
      WR_WAIT: if (mem.mem_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // req/we decode straight from the state flops, so reset drops them without waiting for a clock
  assign accept      = (state == IDLE);
  assign mem.mem_req = (state != IDLE);
  assign mem.mem_we  = (state == WR_WAIT);
  assign o_busy      = ~accept;
`else
  logic unused_ack;
  assign unused_ack  = mem.mem_ack;
  assign accept      = 1'b1;
  assign rd_done     = (i_transfer_cmd == 4'h2);
  assign mem.mem_we  = (i_transfer_cmd == 4'h9);
  assign mem.mem_req = mem.mem_we;
  assign o_busy      = 1'b0;
`endif

  // an access in flight freezes MA/MD, so commands and SP steps are masked; PC increments still land
  assign cmd     = accept ? i_transfer_cmd : 4'h0;
  assign sp_step = accept ? i_inc_dec_sp : 2'b00;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      pc        <= PC_RESET;
      sp        <= SP_RESET;
      ma        <= 8'h00;
      md        <= 8'h00;
      ir        <= 8'h00;
      a         <= 8'h00;
      ap        <= 8'h00;
      out_data  <= 8'h00;
      out_valid <= 1'b0;
    end else begin
      if (i_inc_pc) pc <= pc + 8'd1;
      case (cmd)
        4'h1: ma <= pc;
        4'h3: ir <= md;
        4'h4: ma <= md;
        4'h5: if (i_sel_ap) ap <= md; else a <= md;
        4'h6: ma <= ap;
        4'h7: ma <= sp;
        4'h8: md <= i_sel_ap ? ap : a;
        4'hA: if (i_sel_ap) ap <= i_alu_result; else a <= i_alu_result;
        4'hB: pc <= md;
        4'hC: a <= i_in_data;
        4'hD: out_data <= a;
        4'hE: pc <= ap;
        4'hF: md <= pc;
        default: ;
      endcase
      if (rd_done) md <= mem.mem_rdata;
      case (sp_step)
        2'b01:   sp <= sp + 8'd1;
        2'b10:   sp <= sp - 8'd1;
        default: ;
      endcase
      out_valid <= (cmd == 4'hD);
    end
  end

  assign mem.mem_addr  = ma;
  assign mem.mem_wdata = md;
  assign o_opcode      = ir;
  assign o_a           = a;
  assign o_ap          = ap;
  assign o_pc          = pc;
  assign o_sp          = sp;
  assign o_out_data    = out_data;
  assign o_out_valid   = out_valid;
endmodule
